icache_refill_axi: RTL and testbench

- AXI4 read master on the instruction-cache miss path, directly downstream of the icache.
- Consumes the icache refill request (line address) and issues one 8-beat × 64-bit INCR burst.
- Buffers the 64-byte line, signals completion, then serves 64-bit words selected by the icache's bit index until the icache releases it.

---
 rtl/icache_refill_axi.sv | 252 +++++++++++++++++++++++++
 tb/tb_icache_refill_axi.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_axi.sv
// -----------------------------------------------------------------------------
// icache_refill_axi
//
// AXI4 read master on the instruction-cache miss path. Takes a line refill
// request from the icache, issues one LINE_BEATS x 64-bit INCR burst for the
// 64-byte-aligned line, buffers the returned beats, raises done_o, and then
// serves 64-bit words of the line (selected by fifo_idx_i[8:6]) until the
// icache releases it with fifo_done_i or by dropping req_i.
//
// Optional build macro: ICACHE_REFILL_PERF_EN
//   Adds perf_refill_cnt (bursts started) and perf_busy_cyc (cycles spent in
//   ADDR or DATA). Both are 32-bit, reset to zero and wrap.
//
// Ports:
//   clk, rst           core clock, asynchronous active-high reset
//   req_i, req_addr_i  level refill request and line address from icache
//   fifo_idx_i         bit index into the line buffer (multiple of 64)
//   fifo_done_i        one-cycle pulse: icache finished reading the line
//   done_o             line buffered and readable
//   data_o             line word selected by fifo_idx_i[8:6] (combinational)
//   err_o              sticky error for the current refill
//   ar*                AXI4 read address channel (master side)
//   r*                 AXI4 read data channel (master side)
//   perf_*             performance counters (ICACHE_REFILL_PERF_EN only)
// -----------------------------------------------------------------------------
module icache_refill_axi #(
  parameter int unsigned     ID_W       = 4,
  parameter logic [ID_W-1:0] AXI_ID     = {ID_W{1'b0}},
  parameter int unsigned     LINE_BEATS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_i,
  input  logic [63:0]     req_addr_i,
  input  logic [8:0]      fifo_idx_i,
  input  logic            fifo_done_i,
  output logic            done_o,
  output logic [63:0]     data_o,
  output logic            err_o,
  output logic [ID_W-1:0] arid,
  output logic [63:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [63:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready
`ifdef ICACHE_REFILL_PERF_EN
  ,
  output logic [31:0]     perf_refill_cnt,
  output logic [31:0]     perf_busy_cyc
`endif
);

  // The line is fixed at 8 x 64-bit words, so the beat counter is 3 bits.
  localparam int unsigned       BEAT_W    = 3;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_HOLD = 2'b11
  } state_t;

  state_t              state_r, state_s;
  logic                arvalid_r, arvalid_s;
  logic                rready_r, rready_s;
  logic                done_r, done_s;
  logic                err_r, err_s;
  logic [63:0]         araddr_r, araddr_s;
  logic [BEAT_W-1:0]   beat_cnt_r, beat_cnt_s;
  // Set once all 8 beats are stored but rlast has not arrived yet: further
  // beats are accepted and discarded so they cannot overwrite the line.
  logic                drain_r, drain_s;
  logic                buf_we_s;
  logic                r_fire_s;
  logic [63:0]         line_buf [LINE_BEATS];

  // Low address/index bits are intentionally ignored (line-aligned access).
  logic                unused_s;
  assign unused_s = ^{fifo_idx_i[5:0], req_addr_i[5:0]};

  assign r_fire_s = rvalid & rready_r;

  // Next-state and next-output logic for the refill FSM.
  always_comb begin
    state_s    = state_r;
    arvalid_s  = arvalid_r;
    rready_s   = rready_r;
    done_s     = done_r;
    err_s      = err_r;
    araddr_s   = araddr_r;
    beat_cnt_s = beat_cnt_r;
    drain_s    = drain_r;
    buf_we_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // A release pulse blocks acceptance so a request held high across
        // the release cycle starts a new burst only on the following cycle.
        if (req_i && !fifo_done_i) begin
          state_s    = ST_ADDR;
          araddr_s   = {req_addr_i[63:6], 6'b000000};
          arvalid_s  = 1'b1;
          err_s      = 1'b0;
          beat_cnt_s = {BEAT_W{1'b0}};
          drain_s    = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_ADDR: begin
        if (arready) begin
          arvalid_s = 1'b0;
          rready_s  = 1'b1;
          state_s   = ST_DATA;
        end else begin
          arvalid_s = 1'b1;
        end
      end

      ST_DATA: begin
        if (r_fire_s) begin
          if (rresp != 2'b00) begin
            err_s = 1'b1;
          end else begin
            err_s = err_r;
          end

          if (drain_r) begin
            // Overlong burst: discard beats until the slave ends it.
            if (rlast) begin
              rready_s = 1'b0;
              done_s   = 1'b1;
              state_s  = ST_HOLD;
            end else begin
              state_s = ST_DATA;
            end
          end else begin
            buf_we_s   = 1'b1;
            beat_cnt_s = beat_cnt_r + 3'd1;
            if (rlast) begin
              // Early rlast leaves part of the line unfilled.
              if (beat_cnt_r != LAST_BEAT) begin
                err_s = 1'b1;
              end else begin
                err_s = err_s;
              end
              rready_s = 1'b0;
              done_s   = 1'b1;
              state_s  = ST_HOLD;
            end else if (beat_cnt_r == LAST_BEAT) begin
              err_s   = 1'b1;
              drain_s = 1'b1;
            end else begin
              state_s = ST_DATA;
            end
          end
        end else begin
          state_s = ST_DATA;
        end
      end

      ST_HOLD: begin
        if (fifo_done_i || !req_i) begin
          done_s  = 1'b0;
          state_s = ST_IDLE;
        end else begin
          done_s = 1'b1;
        end
      end

      default: begin
        state_s   = ST_IDLE;
        arvalid_s = 1'b0;
        rready_s  = 1'b0;
        done_s    = 1'b0;
      end
    endcase
  end

  // FSM state and registered control/output register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      arvalid_r  <= 1'b0;
      rready_r   <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      araddr_r   <= 64'h0;
      beat_cnt_r <= {BEAT_W{1'b0}};
      drain_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      arvalid_r  <= arvalid_s;
      rready_r   <= rready_s;
      done_r     <= done_s;
      err_r      <= err_s;
      araddr_r   <= araddr_s;
      beat_cnt_r <= beat_cnt_s;
      drain_r    <= drain_s;
    end
  end

  // Line buffer write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      line_buf[beat_cnt_r] <= rdata;
    end
  end

  assign data_o  = line_buf[fifo_idx_i[8:6]];
  assign done_o  = done_r;
  assign err_o   = err_r;
  assign arvalid = arvalid_r;
  assign rready  = rready_r;
  assign araddr  = araddr_r;
  assign arid    = AXI_ID;
  assign arlen   = 8'(LINE_BEATS - 1);
  assign arsize  = 3'b011;
  assign arburst = 2'b01;

`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0] perf_refill_cnt_r;
  logic [31:0] perf_busy_cyc_r;

  // Refill and busy-cycle counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_refill_cnt_r <= 32'h0;
      perf_busy_cyc_r   <= 32'h0;
    end else begin
      if ((state_r == ST_IDLE) && (state_s == ST_ADDR)) begin
        perf_refill_cnt_r <= perf_refill_cnt_r + 32'd1;
      end
      if ((state_r == ST_ADDR) || (state_r == ST_DATA)) begin
        perf_busy_cyc_r <= perf_busy_cyc_r + 32'd1;
      end
    end
  end

  assign perf_refill_cnt = perf_refill_cnt_r;
  assign perf_busy_cyc   = perf_busy_cyc_r;
`endif

endmodule

// File: tb/tb_icache_refill_axi.sv
// -----------------------------------------------------------------------------
// tb_icache_refill_axi
//
// Directed self-checking bench for icache_refill_axi. Each scenario task drives
// a refill through a small AXI slave driver and compares DUT outputs against
// hand-computed values. Inputs change 1 time unit after the rising edge and
// outputs are sampled there or on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_icache_refill_axi;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic [63:0] req_addr_i;
  logic [8:0]  fifo_idx_i;
  logic        fifo_done_i;
  logic        done_o;
  logic [63:0] data_o;
  logic        err_o;
  logic [3:0]  arid;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0] perf_refill_cnt;
  logic [31:0] perf_busy_cyc;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  icache_refill_axi #(.ID_W(4), .AXI_ID(4'h0), .LINE_BEATS(8)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .req_addr_i(req_addr_i),
    .fifo_idx_i(fifo_idx_i), .fifo_done_i(fifo_done_i), .done_o(done_o),
    .data_o(data_o), .err_o(err_o), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
`ifdef ICACHE_REFILL_PERF_EN
    , .perf_refill_cnt(perf_refill_cnt), .perf_busy_cyc(perf_busy_cyc)
`endif
  );

  // Drives one refill: raises req_i, serves AR after ar_delay stall cycles,
  // then nbeats R beats (gap idle cycles before each). Beat b carries
  // dbase*(b+1); rresp=2'b10 on beat err_at; rlast on beat last_at.
  // Leaves the DUT expected in HOLD with req_i still high.
  task automatic drive_refill(input logic [63:0] addr, input int ar_delay,
                              input int gap, input int nbeats, input int last_at,
                              input int err_at, input logic [63:0] dbase,
                              output logic [63:0] addr_seen, output int addr_moves,
                              output int early_done, output logic done_after,
                              output logic err_first, output logic timeout);
    int n;
    addr_moves = 0;
    early_done = 0;
    timeout    = 1'b0;
    req_addr_i = addr;
    req_i      = 1'b1;
    @(posedge clk); #1;
    addr_seen = araddr;
    err_first = err_o;
    for (int k = 0; k < ar_delay; k++) begin
      @(posedge clk); #1;
      if (araddr !== addr_seen || arvalid !== 1'b1) addr_moves++;
    end
    arready = 1'b1;
    n = 0;
    while (arvalid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) timeout = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        if (done_o === 1'b1) early_done++;
      end
      rvalid = 1'b1;
      rdata  = dbase * 64'(b + 1);
      rresp  = (b == err_at) ? 2'b10 : 2'b00;
      rlast  = (b == last_at);
      n = 0;
      while (rready !== 1'b1 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 20) timeout = 1'b1;
      @(posedge clk); #1;
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      if (b != nbeats - 1 && done_o === 1'b1) early_done++;
    end
    done_after = done_o;
  endtask

  // Releases the line with a fifo_done_i pulse and req_i low.
  task automatic release_line();
    req_i       = 1'b0;
    fifo_done_i = 1'b1;
    @(posedge clk); #1;
    fifo_done_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_cmp++; if (arvalid !== 1'b0) begin n_bad++; $display("FAIL reset_arvalid got=%b want=0", arvalid); end
    n_cmp++; if (rready !== 1'b0) begin n_bad++; $display("FAIL reset_rready got=%b want=0", rready); end
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", err_o); end
    n_cmp++; if (araddr !== 64'h0) begin n_bad++; $display("FAIL reset_araddr got=%h want=0", araddr); end
    #10;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [63:0] a; int mv, ed; logic da, ef, to;
    drive_refill(64'h0000_0000_8000_1234, 0, 0, 8, 7, -1, 64'h11, a, mv, ed, da, ef, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL basic_timeout got=%b want=0", to); end
    n_cmp++; if (a !== 64'h0000_0000_8000_1200) begin n_bad++; $display("FAIL basic_araddr got=%h want=0000000080001200", a); end
    n_cmp++; if (arlen !== 8'd7) begin n_bad++; $display("FAIL basic_arlen got=%0d want=7", arlen); end
    n_cmp++; if (arsize !== 3'd3) begin n_bad++; $display("FAIL basic_arsize got=%0d want=3", arsize); end
    n_cmp++; if (arburst !== 2'd1) begin n_bad++; $display("FAIL basic_arburst got=%0d want=1", arburst); end
    n_cmp++; if (arid !== 4'h0) begin n_bad++; $display("FAIL basic_arid got=%h want=0", arid); end
    n_cmp++; if (ed !== 0) begin n_bad++; $display("FAIL basic_early_done got=%0d want=0", ed); end
    n_cmp++; if (da !== 1'b1) begin n_bad++; $display("FAIL basic_done got=%b want=1", da); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL basic_err got=%b want=0", err_o); end
    n_cmp++; if (rready !== 1'b0) begin n_bad++; $display("FAIL basic_rready_hold got=%b want=0", rready); end
    for (int i = 0; i < 8; i++) begin
      fifo_idx_i = 9'(i * 64 + i * 5);
      @(negedge clk);
      n_cmp++; if (data_o !== 64'h11 * 64'(i + 1)) begin n_bad++; $display("FAIL basic_data[%0d] got=%h want=%h", i, data_o, 64'h11 * 64'(i + 1)); end
    end
    @(posedge clk); #1;
    release_line();
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL basic_release got=%b want=0", done_o); end
  endtask

  task automatic test_slow();
    logic [63:0] a; int mv, ed; logic da, ef, to;
    logic [63:0] base = 64'h0102_0304_0506_0708;
    drive_refill(64'h0000_0040_dead_bef7, 5, 1, 8, 7, -1, base, a, mv, ed, da, ef, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL slow_timeout got=%b want=0", to); end
    n_cmp++; if (a !== 64'h0000_0040_dead_bec0) begin n_bad++; $display("FAIL slow_araddr got=%h want=00000040deadbec0", a); end
    n_cmp++; if (mv !== 0) begin n_bad++; $display("FAIL slow_addr_stable got=%0d want=0", mv); end
    n_cmp++; if (ed !== 0) begin n_bad++; $display("FAIL slow_early_done got=%0d want=0", ed); end
    n_cmp++; if (da !== 1'b1) begin n_bad++; $display("FAIL slow_done got=%b want=1", da); end
    for (int i = 0; i < 8; i++) begin
      fifo_idx_i = 9'(i * 64);
      @(negedge clk);
      n_cmp++; if (data_o !== base * 64'(i + 1)) begin n_bad++; $display("FAIL slow_data[%0d] got=%h want=%h", i, data_o, base * 64'(i + 1)); end
    end
    @(posedge clk); #1;
    release_line();
  endtask

  task automatic test_resp_err();
    logic [63:0] a; int mv, ed; logic da, ef, to;
    drive_refill(64'h0000_0000_0000_2000, 1, 0, 8, 7, 2, 64'h33, a, mv, ed, da, ef, to);
    n_cmp++; if (da !== 1'b1) begin n_bad++; $display("FAIL resp_done got=%b want=1", da); end
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL resp_err got=%b want=1", err_o); end
    for (int i = 0; i < 8; i++) begin
      fifo_idx_i = 9'(i * 64);
      @(negedge clk);
      n_cmp++; if (data_o !== 64'h33 * 64'(i + 1)) begin n_bad++; $display("FAIL resp_data[%0d] got=%h want=%h", i, data_o, 64'h33 * 64'(i + 1)); end
    end
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL resp_err_hold got=%b want=1", err_o); end
    @(posedge clk); #1;
    release_line();
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL resp_err_idle got=%b want=1", err_o); end
    drive_refill(64'h0000_0000_0000_2040, 0, 0, 8, 7, -1, 64'h44, a, mv, ed, da, ef, to);
    n_cmp++; if (ef !== 1'b0) begin n_bad++; $display("FAIL resp_err_clear got=%b want=0", ef); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL resp_err_next got=%b want=0", err_o); end
    release_line();
  endtask

  task automatic test_early_last();
    logic [63:0] a; int mv, ed; logic da, ef, to;
    drive_refill(64'h0000_0000_0000_3000, 0, 0, 5, 4, -1, 64'h55, a, mv, ed, da, ef, to);
    n_cmp++; if (ed !== 0) begin n_bad++; $display("FAIL early_early_done got=%0d want=0", ed); end
    n_cmp++; if (da !== 1'b1) begin n_bad++; $display("FAIL early_done got=%b want=1", da); end
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL early_err got=%b want=1", err_o); end
    fifo_idx_i = 9'd256;
    @(negedge clk);
    n_cmp++; if (data_o !== 64'h55 * 64'd5) begin n_bad++; $display("FAIL early_data4 got=%h want=%h", data_o, 64'h55 * 64'd5); end
    @(posedge clk); #1;
    release_line();
  endtask

  task automatic test_overrun();
    logic [63:0] a; int mv, ed; logic da, ef, to;
    drive_refill(64'h0000_0000_0000_4000, 0, 0, 10, 9, -1, 64'hA5, a, mv, ed, da, ef, to);
    n_cmp++; if (ed !== 0) begin n_bad++; $display("FAIL over_early_done got=%0d want=0", ed); end
    n_cmp++; if (da !== 1'b1) begin n_bad++; $display("FAIL over_done got=%b want=1", da); end
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL over_err got=%b want=1", err_o); end
    fifo_idx_i = 9'd0;
    @(negedge clk);
    n_cmp++; if (data_o !== 64'hA5) begin n_bad++; $display("FAIL over_data0 got=%h want=00000000000000a5", data_o); end
    fifo_idx_i = 9'd64;
    @(negedge clk);
    n_cmp++; if (data_o !== 64'h14A) begin n_bad++; $display("FAIL over_data1 got=%h want=000000000000014a", data_o); end
    fifo_idx_i = 9'd448;
    @(negedge clk);
    n_cmp++; if (data_o !== 64'h528) begin n_bad++; $display("FAIL over_data7 got=%h want=0000000000000528", data_o); end
    @(posedge clk); #1;
    release_line();
  endtask

  task automatic test_release_and_reset();
    logic [63:0] a; int mv, ed; logic da, ef, to;
    drive_refill(64'h0000_0000_0000_5000, 0, 0, 8, 7, -1, 64'h66, a, mv, ed, da, ef, to);
    fifo_done_i = 1'b1;
    @(posedge clk); #1;
    fifo_done_i = 1'b0;
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL rel_done got=%b want=0", done_o); end
    n_cmp++; if (arvalid !== 1'b0) begin n_bad++; $display("FAIL rel_idle_arvalid got=%b want=0", arvalid); end
    @(posedge clk); #1;
    n_cmp++; if (arvalid !== 1'b1) begin n_bad++; $display("FAIL rel_new_arvalid got=%b want=1", arvalid); end
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 64'h77;
    @(posedge clk);
    @(posedge clk); #1;
    rvalid = 1'b0;
    n_cmp++; if (rready !== 1'b1) begin n_bad++; $display("FAIL rst_pre_rready got=%b want=1", rready); end
    req_i = 1'b0;
    rst   = 1'b1;
    #1;
    n_cmp++; if (rready !== 1'b0) begin n_bad++; $display("FAIL rst_rready got=%b want=0", rready); end
    n_cmp++; if (arvalid !== 1'b0) begin n_bad++; $display("FAIL rst_arvalid got=%b want=0", arvalid); end
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%b want=0", done_o); end
    #10;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_recovery();
    logic [63:0] a; int mv, ed; logic da, ef, to;
    drive_refill(64'h0000_0000_0000_6008, 2, 0, 8, 7, -1, 64'h5A, a, mv, ed, da, ef, to);
    n_cmp++; if (a !== 64'h0000_0000_0000_6000) begin n_bad++; $display("FAIL recov_araddr got=%h want=0000000000006000", a); end
    n_cmp++; if (da !== 1'b1) begin n_bad++; $display("FAIL recov_done got=%b want=1", da); end
    fifo_idx_i = 9'd192;
    @(negedge clk);
    n_cmp++; if (data_o !== 64'h168) begin n_bad++; $display("FAIL recov_data3 got=%h want=0000000000000168", data_o); end
    @(posedge clk); #1;
    release_line();
  endtask

`ifdef ICACHE_REFILL_PERF_EN
  task automatic test_perf();
    logic [63:0] a; int mv, ed; logic da, ef, to;
    rst = 1'b1;
    #10;
    rst = 1'b0;
    @(posedge clk); #1;
    drive_refill(64'h0000_0000_0000_7000, 3, 0, 8, 7, -1, 64'h1, a, mv, ed, da, ef, to);
    release_line();
    drive_refill(64'h0000_0000_0000_7040, 3, 0, 8, 7, -1, 64'h2, a, mv, ed, da, ef, to);
    release_line();
    n_cmp++; if (perf_refill_cnt !== 32'd2) begin n_bad++; $display("FAIL perf_refill got=%0d want=2", perf_refill_cnt); end
    n_cmp++; if (perf_busy_cyc !== 32'd24) begin n_bad++; $display("FAIL perf_busy got=%0d want=24", perf_busy_cyc); end
  endtask
`endif

  initial begin
    rst         = 1'b1;
    req_i       = 1'b0;
    req_addr_i  = 64'h0;
    fifo_idx_i  = 9'd0;
    fifo_done_i = 1'b0;
    arready     = 1'b0;
    rdata       = 64'h0;
    rresp       = 2'b00;
    rlast       = 1'b0;
    rvalid      = 1'b0;
    test_reset();
    test_basic();
    test_slow();
    test_resp_err();
    test_early_last();
    test_overrun();
    test_release_and_reset();
    test_recovery();
`ifdef ICACHE_REFILL_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
